// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   tx_state_t     bit-timing FSM states (PARITY only used with UART_TX_PARITY_EN)
//   UART_DATA_BITS payload width of one frame
//   clks_per_bit() clock cycles per serial bit, integer divide of CLK_HZ by BAUD
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO that buffers bytes waiting to be serialised.
// Ports:
//   clk      sole clock, posedge
//   reset    asynchronous active-high, empties the FIFO
//   i_push   write request, ignored while full
//   i_pop    read request, ignored while empty
//   i_data   write data
//   o_data   head of the FIFO (valid while !o_empty)
//   o_full   no free entry
//   o_empty  no stored entry
//   o_count  number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Fullness is judged on the registered count only, so a push is refused
    // when full even if the same edge pops an entry.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage has no reset; stale entries are never visible because count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter, LSB first, line idles high. Bytes arrive on a
// valid/ready port, wait in a small FIFO and are serialised by a bit-timing FSM.
// Build option: define UART_TX_PARITY_EN for 8E1 framing (even parity bit after
// the data bits); otherwise frames are 8N1. The port list is the same in both.
// Ports:
//   clk         sole clock, posedge
//   reset       asynchronous active-high, clears all state and forces the line high
//   tx_data     byte to send, taken when tx_valid && tx_ready
//   tx_valid    producer has a byte
//   tx_ready    FIFO not full
//   serial_out  registered UART line
//   busy        registered alongside serial_out: high while a frame is on the line
//               or bytes are buffered
//   fifo_count  bytes currently buffered
//   overflow    sticky, set by tx_valid while !tx_ready, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_DATA_BITS-1:0]       tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            serial_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 r_state;
    tx_state_t                 w_next_state;
    logic [BAUD_W-1:0]         r_baud_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_serial;
    logic                      r_busy;
    logic                      r_overflow;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity;
`endif
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_bit_done;
    logic                      w_line;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_valid),
        .i_pop   (w_pop),
        .i_data  (tx_data),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign tx_ready   = !w_full;
    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign w_bit_done = (r_baud_cnt == BAUD_LAST);

    // Next state, FIFO pop and the line level for the current state. The line
    // level is registered, so serial_out trails the state by one clock.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_line       = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = START;
                end
            end
            START: begin
                w_line = 1'b0;
                if (w_bit_done) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_line = r_shift[0];
                if (w_bit_done && (r_bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_line = r_parity;
                if (w_bit_done) begin
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when bytes are waiting.
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, baud timing, shift register, line and status registers. Every
    // state change outside IDLE happens on w_bit_done, so reloading the baud
    // counter on w_bit_done covers both bit and state boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state  <= w_next_state;
            r_serial <= w_line;
            r_busy   <= (r_state != IDLE) || !w_empty;
            if (tx_valid && !tx_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_bit_done || (r_state == IDLE)) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^w_fifo_data;
`endif
            end else if ((r_state == DATA) && w_bit_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered at CLK_HZ=1000, BAUD=100 (10 clocks
// per bit). Single frames come from a table of hand-computed line patterns;
// back-to-back frames, FIFO full/overflow, mid-frame reset and the full-FIFO
// push/pop collision are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame8n1;
        logic [10:0] frame8e1;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    uart_tx_buffered #(
        .CLK_HZ     (1000),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // 10 ns clock and a cycle counter used as the time base for bit sampling.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        tx_valid = v;
        tx_data  = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitCycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        checkOutput("idle_timeout", busy, 0);
    endtask

    // Expected line level of bit j of a frame carrying d (start, data LSB first,
    // optional even parity, stop).
    function automatic logic frameBit(input logic [7:0] d, input int j);
        if (j == 0)            return 1'b0;
        if (j <= 8)            return d[j-1];
        if (NB == 11 && j == 9) return ^d;
        return 1'b1;
    endfunction

    // Samples frame number idx of a contiguous stream whose line fell at n0+2,
    // taking each bit in the middle of its 10-clock window.
    task automatic checkFrame(input int n0, input int idx, input logic [7:0] d);
        logic [10:0] got;
        logic [10:0] exp;
        got = '0;
        exp = '0;
        for (int j = 0; j < NB; j++) begin
            waitCycle(n0 + 7 + 10 * (idx * NB + j));
            got[j] = serial_out;
            exp[j] = frameBit(d, j);
        end
        checkOutput($sformatf("stream_frame%0d", idx), got, exp);
    endtask

    // Single frame from idle against a hand-computed line pattern.
    task automatic sendAndCheck(input logic [7:0] d, input logic [10:0] exp);
        int          n0;
        logic [10:0] got;
        applyStimulus(1'b1, d);
        checkOutput("ready_idle", tx_ready, 1);
        tick(1);
        n0 = cyc;
        applyStimulus(1'b0, 8'h00);
        checkOutput("count_after_push", fifo_count, 1);
        tick(1);
        checkOutput("line_before_start", serial_out, 1);
        tick(1);
        checkOutput("line_start_edge", serial_out, 0);
        got = '0;
        for (int j = 0; j < NB; j++) begin
            waitCycle(n0 + 7 + 10 * j);
            got[j] = serial_out;
        end
        checkOutput($sformatf("frame_%02h", d), got, exp);
        waitCycle(n0 + 1 + 10 * NB);
        checkOutput("busy_last_clk", busy, 1);
        tick(1);
        checkOutput("busy_drop", busy, 0);
        checkOutput("line_idle", serial_out, 1);
    endtask

    initial begin
        int n0;

        vecs[0] = '{data: 8'hA5, frame8n1: 11'h34A, frame8e1: 11'h54A};
        vecs[1] = '{data: 8'h00, frame8n1: 11'h200, frame8e1: 11'h400};
        vecs[2] = '{data: 8'hFF, frame8n1: 11'h3FE, frame8e1: 11'h5FE};
        vecs[3] = '{data: 8'h5A, frame8n1: 11'h2B4, frame8e1: 11'h4B4};
        vecs[4] = '{data: 8'h07, frame8n1: 11'h20E, frame8e1: 11'h60E};
        vecs[5] = '{data: 8'h03, frame8n1: 11'h206, frame8e1: 11'h406};

        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);
        tick(3);
        reset = 1'b0;
        tick(2);
        checkOutput("rst_serial", serial_out, 1);
        checkOutput("rst_ready", tx_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_overflow", overflow, 0);

        // Single frames, including the parity cases when parity is built in.
        for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_PARITY_EN
            sendAndCheck(vecs[i].data, vecs[i].frame8e1);
`else
            sendAndCheck(vecs[i].data, vecs[i].frame8n1);
`endif
        end

        // Three pushes on consecutive edges. The first byte is popped on the
        // edge that takes the second, so the count reads 1, 1, 2.
        applyStimulus(1'b1, 8'h01);
        tick(1);
        n0 = cyc;
        checkOutput("b2b_count1", fifo_count, 1);
        applyStimulus(1'b1, 8'h02);
        tick(1);
        checkOutput("b2b_count2", fifo_count, 1);
        applyStimulus(1'b1, 8'h03);
        tick(1);
        checkOutput("b2b_count3", fifo_count, 2);
        applyStimulus(1'b0, 8'h00);
        checkFrame(n0, 0, 8'h01);
        checkOutput("b2b_count_f0", fifo_count, 2);
        checkFrame(n0, 1, 8'h02);
        checkOutput("b2b_count_f1", fifo_count, 1);
        checkFrame(n0, 2, 8'h03);
        checkOutput("b2b_count_f2", fifo_count, 0);
        waitIdle();

        // Fill the FIFO while a frame is sending, then offer one byte too many.
        applyStimulus(1'b1, 8'h11);
        tick(1);
        n0 = cyc;
        applyStimulus(1'b1, 8'h21);
        tick(1);
        applyStimulus(1'b1, 8'h22);
        tick(1);
        applyStimulus(1'b1, 8'h23);
        tick(1);
        applyStimulus(1'b1, 8'h24);
        tick(1);
        checkOutput("full_ready", tx_ready, 0);
        checkOutput("full_count", fifo_count, 4);
        checkOutput("full_no_ovf", overflow, 0);
        applyStimulus(1'b1, 8'h25);
        tick(1);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_count", fifo_count, 4);
        applyStimulus(1'b0, 8'h00);
        checkFrame(n0, 0, 8'h11);
        checkFrame(n0, 1, 8'h21);
        checkFrame(n0, 2, 8'h22);
        checkFrame(n0, 3, 8'h23);
        checkFrame(n0, 4, 8'h24);
        waitIdle();
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_drained", fifo_count, 0);

        // Hold a push against a full FIFO across the edge the FSM pops.
        applyStimulus(1'b1, 8'h31);
        tick(1);
        n0 = cyc;
        applyStimulus(1'b1, 8'h32);
        tick(1);
        applyStimulus(1'b1, 8'h33);
        tick(1);
        applyStimulus(1'b1, 8'h34);
        tick(1);
        applyStimulus(1'b1, 8'h35);
        tick(1);
        applyStimulus(1'b1, 8'h66);
        waitCycle(n0 + 10 * NB);
        checkOutput("collide_pre_count", fifo_count, 4);
        checkOutput("collide_pre_ready", tx_ready, 0);
        tick(1);
        checkOutput("collide_count", fifo_count, 3);
        checkOutput("collide_ready", tx_ready, 1);
        applyStimulus(1'b0, 8'h00);
        checkFrame(n0, 1, 8'h32);
        checkFrame(n0, 2, 8'h33);
        checkFrame(n0, 3, 8'h34);
        checkFrame(n0, 4, 8'h35);
        waitIdle();
        checkOutput("collide_drained", fifo_count, 0);

        // Reset 35 clocks into a 0xFF frame with another byte still buffered.
        applyStimulus(1'b1, 8'hFF);
        tick(1);
        n0 = cyc;
        applyStimulus(1'b1, 8'h00);
        tick(1);
        applyStimulus(1'b0, 8'h00);
        waitCycle(n0 + 2 + 35);
        checkOutput("mid_count", fifo_count, 1);
        checkOutput("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("mrst_serial", serial_out, 1);
        checkOutput("mrst_count", fifo_count, 0);
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_ready", tx_ready, 1);
        checkOutput("mrst_overflow", overflow, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
`ifdef UART_TX_PARITY_EN
        sendAndCheck(8'h5A, 11'h4B4);
`else
        sendAndCheck(8'h5A, 11'h2B4);
`endif
        checkOutput("final_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
